// File: rtl/wb_timeout.sv
// Wishbone pass-through register stage that aborts a slave access with an error
// when the slave takes too long to respond.
module wb_timeout #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic                    wbm_rty_o,
    input  logic                    wbm_cyc_i,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    wbs_cyc_o,

    output logic                    timeout_o
);

    // state    | meaning
    // IDLE     | forward master cyc, wait for a new master strobe
    // WAIT_ACK | request issued to slave, counting wait cycles
    // ABORT    | timeout fired, slave cyc held low for one cycle
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ABORT    = 2'd2
    } state_t;

    localparam int             CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cnt_tc;

    // cnt_tc is the registered terminal-count compare; acting on it instead of
    // cnt directly puts the error TIMEOUT+1 cycles after the slave strobe rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cnt_tc    <= 1'b0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_sel_o <= '0;
            wbs_stb_o <= 1'b0;
            wbs_cyc_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    cnt_tc    <= 1'b0;
                    wbs_cyc_o <= wbm_cyc_i;
                    if (wbm_cyc_i && wbm_stb_i && !(wbm_ack_o || wbm_err_o || wbm_rty_o)) begin
                        wbs_adr_o <= wbm_adr_i;
                        wbs_dat_o <= wbm_dat_i;
                        wbs_we_o  <= wbm_we_i;
                        wbs_sel_o <= wbm_sel_i;
                        wbs_stb_o <= 1'b1;
                        wbs_cyc_o <= 1'b1;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!wbm_cyc_i) begin
                        wbs_stb_o <= 1'b0;
                        wbs_we_o  <= 1'b0;
                        wbs_cyc_o <= 1'b0;
                        state     <= IDLE;
                    end else if (wbs_ack_i || wbs_err_i || wbs_rty_i) begin
                        wbm_dat_o <= wbs_dat_i;
                        wbm_ack_o <= wbs_ack_i;
                        wbm_err_o <= wbs_err_i;
                        wbm_rty_o <= wbs_rty_i;
                        wbs_stb_o <= 1'b0;
                        wbs_we_o  <= 1'b0;
                        wbs_cyc_o <= wbm_cyc_i;
                        state     <= IDLE;
                    end else if (cnt_tc) begin
                        wbm_err_o <= 1'b1;
                        timeout_o <= 1'b1;
                        wbs_stb_o <= 1'b0;
                        wbs_we_o  <= 1'b0;
                        wbs_cyc_o <= 1'b0;
                        state     <= ABORT;
                    end else begin
                        if (cnt != CNT_MAX)
                            cnt <= cnt + 1'b1;
                        cnt_tc <= (cnt == CNT_MAX);
                    end
                end
                ABORT: begin
                    wbs_cyc_o <= wbm_cyc_i;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_timeout.sv
// Directed bench for wb_timeout (TIMEOUT=8); master responses are checked
// against a queue of expected responses filled when slave stimulus is driven.
module tb_wb_timeout;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wbm_adr_i;
    logic [DW-1:0] wbm_dat_i;
    logic [DW-1:0] wbm_dat_o;
    logic          wbm_we_i;
    logic [SW-1:0] wbm_sel_i;
    logic          wbm_stb_i;
    logic          wbm_ack_o;
    logic          wbm_err_o;
    logic          wbm_rty_o;
    logic          wbm_cyc_i;
    logic [AW-1:0] wbs_adr_o;
    logic [DW-1:0] wbs_dat_i;
    logic [DW-1:0] wbs_dat_o;
    logic          wbs_we_o;
    logic [SW-1:0] wbs_sel_o;
    logic          wbs_stb_o;
    logic          wbs_ack_i;
    logic          wbs_err_i;
    logic          wbs_rty_i;
    logic          wbs_cyc_o;
    logic          timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          ack;
        logic          err;
        logic          rty;
        logic          to;
        logic          chk_dat;
        logic [DW-1:0] dat;
    } resp_t;

    resp_t sb[$];

    wb_timeout #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SELECT_WIDTH(SW),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wbm_adr_i(wbm_adr_i),
        .wbm_dat_i(wbm_dat_i),
        .wbm_dat_o(wbm_dat_o),
        .wbm_we_i(wbm_we_i),
        .wbm_sel_i(wbm_sel_i),
        .wbm_stb_i(wbm_stb_i),
        .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbm_cyc_i(wbm_cyc_i),
        .wbs_adr_o(wbs_adr_o),
        .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o),
        .wbs_we_o(wbs_we_o),
        .wbs_sel_o(wbs_sel_o),
        .wbs_stb_o(wbs_stb_o),
        .wbs_ack_i(wbs_ack_i),
        .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i),
        .wbs_cyc_o(wbs_cyc_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; any master response seen must match the queue head.
    task automatic tick();
        resp_t e;
        @(posedge clk);
        #1;
        if (wbm_ack_o || wbm_err_o || wbm_rty_o || timeout_o) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 4'b0000);
            end else begin
                e = sb.pop_front();
                check("resp_flags", {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o},
                      {e.ack, e.err, e.rty, e.to});
                if (e.chk_dat)
                    check("resp_dat", wbm_dat_o, e.dat);
            end
        end
    endtask

    task automatic master_req(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              input logic we, input logic [SW-1:0] sel);
        wbm_adr_i = adr;
        wbm_dat_i = dat;
        wbm_we_i  = we;
        wbm_sel_i = sel;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        tick();
        check("stb_rise", wbs_stb_o, 1'b1);
    endtask

    task automatic master_idle();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_we_i  = 1'b0;
        wbm_sel_i = '0;
        wbm_stb_i = 1'b0;
        wbm_cyc_i = 1'b0;
        wbs_dat_i = '0;
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
        tick();
        tick();
        check("rst_strobes", {wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 6'b0);
        check("rst_wbs_fields", {wbs_adr_o, wbs_dat_o}, 64'h0);
        check("rst_misc", {wbm_dat_o, wbs_sel_o, wbs_we_o}, 37'h0);
        rst = 1'b0;
        tick();

        // Write, slave acks three cycles after the strobe rises.
        master_req(32'h100, 32'hDEADBEEF, 1'b1, 4'hF);
        check("wr_adr", wbs_adr_o, 32'h100);
        check("wr_dat", wbs_dat_o, 32'hDEADBEEF);
        check("wr_sel", wbs_sel_o, 4'hF);
        check("wr_we_cyc", {wbs_we_o, wbs_cyc_o}, 2'b11);
        tick();
        tick();
        tick();
        wbs_ack_i = 1'b1;
        sb.push_back('{ack: 1'b1, err: 1'b0, rty: 1'b0, to: 1'b0, chk_dat: 1'b1, dat: 32'h0});
        tick();
        check("wr_ack_latency", wbm_ack_o, 1'b1);
        check("wr_no_timeout", timeout_o, 1'b0);
        check("wr_stb_drop", {wbs_stb_o, wbs_we_o, wbs_cyc_o}, 3'b001);
        wbs_ack_i = 1'b0;
        master_idle();
        tick();
        check("wr_cyc_forward", wbs_cyc_o, 1'b0);
        check("wr_sb_empty", 64'(sb.size()), 64'd0);

        // Read, slave returns data on the second wait cycle.
        master_req(32'h200, 32'h0, 1'b0, 4'hF);
        check("rd_we", wbs_we_o, 1'b0);
        tick();
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h12345678;
        sb.push_back('{ack: 1'b1, err: 1'b0, rty: 1'b0, to: 1'b0, chk_dat: 1'b1, dat: 32'h12345678});
        tick();
        wbs_ack_i = 1'b0;
        wbs_dat_i = '0;
        master_idle();
        tick();
        check("rd_ack_one_cycle", wbm_ack_o, 1'b0);
        check("rd_sb_empty", 64'(sb.size()), 64'd0);

        // Silent slave: error and timeout nine cycles after the strobe rises.
        master_req(32'h300, 32'h0, 1'b0, 4'h3);
        for (int i = 1; i <= 8; i++) tick();
        sb.push_back('{ack: 1'b0, err: 1'b1, rty: 1'b0, to: 1'b1, chk_dat: 1'b0, dat: 32'h0});
        tick();
        check("to_pulse", {wbm_err_o, timeout_o}, 2'b11);
        check("to_abort_bus", {wbs_stb_o, wbs_we_o, wbs_cyc_o}, 3'b000);
        wbm_stb_i = 1'b0;
        wbs_ack_i = 1'b1;
        tick();
        check("to_late_ack_ignored", {wbm_ack_o, wbm_err_o, timeout_o}, 3'b000);
        check("to_cyc_restored", wbs_cyc_o, 1'b1);
        wbs_ack_i = 1'b0;
        master_idle();
        tick();
        check("to_sb_empty", 64'(sb.size()), 64'd0);

        // Slave ack on the same cycle the timeout would fire: ack wins.
        master_req(32'h400, 32'h0, 1'b0, 4'h1);
        for (int i = 1; i <= 8; i++) tick();
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'hA5A5_0F0F;
        sb.push_back('{ack: 1'b1, err: 1'b0, rty: 1'b0, to: 1'b0, chk_dat: 1'b1, dat: 32'hA5A5_0F0F});
        tick();
        check("race_ack_wins", {wbm_ack_o, wbm_err_o, timeout_o}, 3'b100);
        wbs_ack_i = 1'b0;
        wbs_dat_i = '0;
        master_idle();
        tick();
        tick();
        check("race_sb_empty", 64'(sb.size()), 64'd0);

        // Master abandons the cycle while waiting.
        master_req(32'h500, 32'h11, 1'b1, 4'h2);
        tick();
        tick();
        master_idle();
        tick();
        check("cyc_drop_bus", {wbs_stb_o, wbs_cyc_o}, 2'b00);
        check("cyc_drop_no_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);
        tick();

        // Reset in the middle of a wait, with a slave ack colliding.
        master_req(32'h600, 32'h22, 1'b1, 4'h4);
        tick();
        rst       = 1'b1;
        wbs_ack_i = 1'b1;
        tick();
        check("rst_mid_strobes", {wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 6'b0);
        check("rst_mid_fields", {wbs_adr_o, wbs_we_o, wbs_sel_o}, 37'h0);
        tick();
        rst       = 1'b0;
        wbs_ack_i = 1'b0;
        master_idle();
        for (int i = 0; i < 4; i++) tick();
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
